wptr_full_af: RTL

WPTR_FULL_AF -- requirements
Module: wptr_full_af

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/gray2bin_conv.sv | 17 +
 rtl/wptr_full_af.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth constant and Gray/binary pointer conversions.
// Functions work on the widest legal pointer (ADDRSIZE 12 -> 13 bits);
// callers zero-extend in and size-cast the result back to their width.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Width-parametrised Gray-to-binary converter, shared by the read and write
// pointer blocks.
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Purely combinational conversion through the package helper.
  always_comb begin
    bin_o = W'(gray2bin(ptr_t'(gray_i)));
  end

endmodule

// File: rtl/wptr_full_af.sv
// Write-side FIFO pointer block: Gray write pointer, full / almost-full,
// occupancy, sticky overflow and read-pointer sync-error flags.
module wptr_full_af
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE   = 4,
  parameter bit          GRAY_CHECK = 1'b1
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wrptr2,
  input  logic [ADDRSIZE:0]   afull_level,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wr_count,
  output logic [ADDRSIZE:0]   wfree,
  output logic                wovf,
  output logic                wsync_err
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] DEPTH = PW'(fifo_depth(ADDRSIZE));

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] cnt_q, cnt_d;
  logic              wfull_q, wfull_d;
  logic              waf_q, waf_d;
  logic              wovf_q, wovf_d;
  logic              wsync_err_q;
  logic              wacc;
  logic [ADDRSIZE:0] rbin;

  gray2bin_conv #(.W(PW)) u_rptr_g2b (
    .gray_i (wrptr2),
    .bin_o  (rbin)
  );

  // Next-state pointer, full, occupancy and overflow evaluation.
  always_comb begin
    wacc    = winc & ~wfull_q;
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wacc};
    wptr_d  = PW'(bin2gray(ptr_t'(wbin_d)));
    wfull_d = (wptr_d == {~wrptr2[ADDRSIZE:ADDRSIZE-1], wrptr2[ADDRSIZE-2:0]});
    cnt_d   = wbin_d - rbin;
    waf_d   = (cnt_d >= afull_level);
    wovf_d  = wovf_q;
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (ovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  // Registered pointer and status state, synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      wfull_q <= 1'b0;
      waf_q   <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      wfull_q <= wfull_d;
      waf_q   <= waf_d;
      wovf_q  <= wovf_d;
    end
  end

  if (GRAY_CHECK) begin : g_sync_check
    logic [ADDRSIZE:0] rptr_prev_q;
    logic [ADDRSIZE:0] rdiff;
    logic              multi_bit;

    // A legal synchronised Gray pointer moves by at most one bit per edge.
    always_comb begin
      rdiff     = wrptr2 ^ rptr_prev_q;
      multi_bit = ((rdiff & (rdiff - PW'(1))) != '0);
    end

    // Track previous read pointer; sticky error with set winning over clear.
    always_ff @(posedge wclk) begin
      if (wrst) begin
        rptr_prev_q <= '0;
        wsync_err_q <= 1'b0;
      end else begin
        rptr_prev_q <= wrptr2;
        if (multi_bit) begin
          wsync_err_q <= 1'b1;
        end else if (ovf_clr) begin
          wsync_err_q <= 1'b0;
        end
      end
    end
  end else begin : g_no_sync_check
    // Check disabled: flag tied low.
    always_comb begin
      wsync_err_q = 1'b0;
    end
  end

  // Output mapping; free slots derive from the registered count.
  always_comb begin
    waddr        = wbin_q[ADDRSIZE-1:0];
    wptr         = wptr_q;
    wfull        = wfull_q;
    walmost_full = waf_q;
    wr_count     = cnt_q;
    wfree        = DEPTH - cnt_q;
    wovf         = wovf_q;
    wsync_err    = wsync_err_q;
  end

endmodule
